// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles every request, response and memory-side handshake signal of the
//   two-requester memory port arbiter. Vectors use [0:N-1] numbering, so bit 0
//   is the most significant bit.
//
//   Modports:
//     slave  - the arbiter itself (consumes requests, drives memory commands
//              and routed responses)
//     master - the environment around the arbiter: both requesters and the
//              memory, which drive requests, memory readiness and read data
//
//   Per requester r in {0,1}:
//     req_valid_r / req_ready_r           request handshake
//     req_rs_id_r, req_reg_addr_r         tag returned with the response
//     req_address_r, req_write_en_r,
//     req_write_data_r, req_read_en_r     memory command fields
//     rsp_valid_r / rsp_ready_r           response handshake
//     rsp_rs_id_r, rsp_reg_addr_r,
//     rsp_read_data_r                     response payload
//   Memory side:
//     mem_valid / mem_ready               command handshake
//     mem_address, mem_write_en,
//     mem_write_data, mem_read_en         command fields
//     mem_rsp_valid / mem_rsp_ready       response handshake
//     mem_read_data                       response data
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int RS_ID_WIDTH = 5
);
    logic                   req_valid_0;
    logic                   req_ready_0;
    logic [0:RS_ID_WIDTH-1] req_rs_id_0;
    logic [0:4]             req_reg_addr_0;
    logic [0:31]            req_address_0;
    logic [0:3]             req_write_en_0;
    logic [0:31]            req_write_data_0;
    logic [0:3]             req_read_en_0;

    logic                   req_valid_1;
    logic                   req_ready_1;
    logic [0:RS_ID_WIDTH-1] req_rs_id_1;
    logic [0:4]             req_reg_addr_1;
    logic [0:31]            req_address_1;
    logic [0:3]             req_write_en_1;
    logic [0:31]            req_write_data_1;
    logic [0:3]             req_read_en_1;

    logic                   rsp_valid_0;
    logic                   rsp_ready_0;
    logic [0:RS_ID_WIDTH-1] rsp_rs_id_0;
    logic [0:4]             rsp_reg_addr_0;
    logic [0:31]            rsp_read_data_0;

    logic                   rsp_valid_1;
    logic                   rsp_ready_1;
    logic [0:RS_ID_WIDTH-1] rsp_rs_id_1;
    logic [0:4]             rsp_reg_addr_1;
    logic [0:31]            rsp_read_data_1;

    logic                   mem_valid;
    logic                   mem_ready;
    logic [0:31]            mem_address;
    logic [0:3]             mem_write_en;
    logic [0:31]            mem_write_data;
    logic [0:3]             mem_read_en;
    logic                   mem_rsp_valid;
    logic                   mem_rsp_ready;
    logic [0:31]            mem_read_data;

    modport slave (
        input  req_valid_0, req_rs_id_0, req_reg_addr_0, req_address_0,
               req_write_en_0, req_write_data_0, req_read_en_0,
        output req_ready_0,
        input  req_valid_1, req_rs_id_1, req_reg_addr_1, req_address_1,
               req_write_en_1, req_write_data_1, req_read_en_1,
        output req_ready_1,
        output rsp_valid_0, rsp_rs_id_0, rsp_reg_addr_0, rsp_read_data_0,
        input  rsp_ready_0,
        output rsp_valid_1, rsp_rs_id_1, rsp_reg_addr_1, rsp_read_data_1,
        input  rsp_ready_1,
        output mem_valid, mem_address, mem_write_en, mem_write_data, mem_read_en,
        input  mem_ready,
        input  mem_rsp_valid, mem_read_data,
        output mem_rsp_ready
    );

    modport master (
        output req_valid_0, req_rs_id_0, req_reg_addr_0, req_address_0,
               req_write_en_0, req_write_data_0, req_read_en_0,
        input  req_ready_0,
        output req_valid_1, req_rs_id_1, req_reg_addr_1, req_address_1,
               req_write_en_1, req_write_data_1, req_read_en_1,
        input  req_ready_1,
        input  rsp_valid_0, rsp_rs_id_0, rsp_reg_addr_0, rsp_read_data_0,
        output rsp_ready_0,
        input  rsp_valid_1, rsp_rs_id_1, rsp_reg_addr_1, rsp_read_data_1,
        output rsp_ready_1,
        input  mem_valid, mem_address, mem_write_en, mem_write_data, mem_read_en,
        output mem_ready,
        output mem_rsp_valid, mem_read_data,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between two requesters. Each accepted request is
//   tagged into an in-order tracking FIFO ({requester, rs_id, reg_addr}); every
//   memory response (load or store) is routed back to the requester at the
//   FIFO head together with that entry's tag.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset
//     bus  - mem_port_arbiter_if.slave, all request/response/memory signals
//
//   Parameters:
//     RS_ID_WIDTH      - reservation-station tag width
//     MAX_OUTSTANDING  - tracking FIFO depth (power of two, 2..16)
//
//   Build option:
//     MEM_ARB_ROUND_ROBIN_EN - when defined, a contested IDLE selection goes
//     to the requester not granted last; otherwise requester 0 always wins.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int RS_ID_WIDTH     = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT_0, ST_GRANT_1} state_t;

    typedef struct packed {
        logic                   idx;
        logic [RS_ID_WIDTH-1:0] rs_id;
        logic [4:0]             reg_addr;
    } entry_t;

    state_t           state_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    entry_t           fifo_mem [MAX_OUTSTANDING];

    logic   fifo_full;
    logic   fifo_empty;
    logic   sel_valid;
    logic   sel_idx;
    logic   grant_active;
    logic   grant_idx;
    logic   push;
    logic   pop;
    entry_t push_entry;
    entry_t head_entry;
    logic   head_0;
    logic   head_1;

    assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_reg == '0);
    assign sel_valid  = bus.req_valid_0 | bus.req_valid_1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Requester preferred on the next contested selection.
    logic prio_reg;
    assign sel_idx = (bus.req_valid_0 & bus.req_valid_1) ? prio_reg : ~bus.req_valid_0;
`else
    assign sel_idx = ~bus.req_valid_0;
`endif

    // In IDLE the selection passes straight through so a request can
    // transfer in the same cycle; once stalled, the grant is held in state.
    always_comb begin
        grant_active = 1'b0;
        grant_idx    = 1'b0;
        case (state_reg)
            ST_GRANT_0: begin
                grant_active = 1'b1;
                grant_idx    = 1'b0;
            end
            ST_GRANT_1: begin
                grant_active = 1'b1;
                grant_idx    = 1'b1;
            end
            default: begin
                grant_active = sel_valid & ~fifo_full;
                grant_idx    = sel_idx;
            end
        endcase
    end

    always_comb begin
        bus.mem_valid      = grant_active;
        bus.mem_address    = '0;
        bus.mem_write_en   = '0;
        bus.mem_write_data = '0;
        bus.mem_read_en    = '0;
        bus.req_ready_0    = grant_active & ~grant_idx & bus.mem_ready;
        bus.req_ready_1    = grant_active &  grant_idx & bus.mem_ready;
        push_entry         = '0;
        if (grant_active) begin
            if (grant_idx) begin
                bus.mem_address     = bus.req_address_1;
                bus.mem_write_en    = bus.req_write_en_1;
                bus.mem_write_data  = bus.req_write_data_1;
                bus.mem_read_en     = bus.req_read_en_1;
                push_entry.rs_id    = bus.req_rs_id_1;
                push_entry.reg_addr = bus.req_reg_addr_1;
            end else begin
                bus.mem_address     = bus.req_address_0;
                bus.mem_write_en    = bus.req_write_en_0;
                bus.mem_write_data  = bus.req_write_data_0;
                bus.mem_read_en     = bus.req_read_en_0;
                push_entry.rs_id    = bus.req_rs_id_0;
                push_entry.reg_addr = bus.req_reg_addr_0;
            end
            push_entry.idx = grant_idx;
        end
    end

    assign push = grant_active & bus.mem_ready;

    // Response routing: only the head entry's requester ever sees a response.
    assign head_entry = fifo_mem[rd_ptr_reg];
    assign head_0     = ~fifo_empty & ~head_entry.idx;
    assign head_1     = ~fifo_empty &  head_entry.idx;

    always_comb begin
        bus.mem_rsp_ready   = (head_0 & bus.rsp_ready_0) | (head_1 & bus.rsp_ready_1);
        bus.rsp_valid_0     = head_0 & bus.mem_rsp_valid;
        bus.rsp_valid_1     = head_1 & bus.mem_rsp_valid;
        bus.rsp_rs_id_0     = head_0 ? head_entry.rs_id    : '0;
        bus.rsp_reg_addr_0  = head_0 ? head_entry.reg_addr : '0;
        bus.rsp_read_data_0 = head_0 ? bus.mem_read_data   : '0;
        bus.rsp_rs_id_1     = head_1 ? head_entry.rs_id    : '0;
        bus.rsp_reg_addr_1  = head_1 ? head_entry.reg_addr : '0;
        bus.rsp_read_data_1 = head_1 ? bus.mem_read_data   : '0;
    end

    assign pop = bus.mem_rsp_valid & bus.mem_rsp_ready;

    // Grant FSM: a stalled selection is latched so the command stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_active && !bus.mem_ready) begin
                        state_reg <= grant_idx ? ST_GRANT_1 : ST_GRANT_0;
                    end
                end
                default: begin
                    if (bus.mem_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Tracking FIFO control; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg <= 1'b0;
        end else if (push) begin
            prio_reg <= ~grant_idx;
        end
    end
`endif

    // Entry storage needs no reset: occupancy gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Randomized and directed stimulus for mem_port_arbiter, checked each cycle
//   against a transaction-level model: an in-order queue of outstanding
//   requests, the requester currently holding a stalled grant, and the last
//   granted requester. Prints one line per completed request/response.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    localparam int RSW  = 5;
    localparam int MAXO = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.RS_ID_WIDTH(RSW)) bus ();

    mem_port_arbiter #(
        .RS_ID_WIDTH    (RSW),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int             idx;
        logic [RSW-1:0] rs;
        logic [4:0]     rd;
    } ent_t;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    // Reference model state
    ent_t q[$];
    int   locked = -1;
    int   last   = 1;
    int   exp_g  = -1;

    // Requester pending requests (valid held until accepted)
    logic           pend_valid [2];
    logic [RSW-1:0] pend_rs    [2];
    logic [4:0]     pend_rd    [2];
    logic [31:0]    pend_addr  [2];
    logic [3:0]     pend_we    [2];
    logic [31:0]    pend_wd    [2];
    logic [3:0]     pend_re    [2];

    logic        drv_mem_ready;
    logic        drv_rsp_valid;
    logic        drv_rsp_ready [2];
    logic [31:0] drv_rdata;

    int p_req [2];
    int p_mem_ready;
    int p_rsp_valid;
    int p_rsp_ready [2];
    int p_rst;

    // Observed DUT outputs, sampled at the falling edge
    logic           obs_req_ready [2];
    logic           obs_rsp_valid [2];
    logic [RSW-1:0] obs_rsp_rs    [2];
    logic [4:0]     obs_rsp_rd    [2];
    logic [31:0]    obs_rsp_data  [2];
    logic           obs_mem_valid;
    logic [31:0]    obs_mem_addr;
    logic [3:0]     obs_mem_we;
    logic [31:0]    obs_mem_wd;
    logic [3:0]     obs_mem_re;
    logic           obs_mem_rsp_ready;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic void apply_drive();
        bus.req_valid_0      = pend_valid[0] && !rst;
        bus.req_rs_id_0      = pend_rs[0];
        bus.req_reg_addr_0   = pend_rd[0];
        bus.req_address_0    = pend_addr[0];
        bus.req_write_en_0   = pend_we[0];
        bus.req_write_data_0 = pend_wd[0];
        bus.req_read_en_0    = pend_re[0];
        bus.req_valid_1      = pend_valid[1] && !rst;
        bus.req_rs_id_1      = pend_rs[1];
        bus.req_reg_addr_1   = pend_rd[1];
        bus.req_address_1    = pend_addr[1];
        bus.req_write_en_1   = pend_we[1];
        bus.req_write_data_1 = pend_wd[1];
        bus.req_read_en_1    = pend_re[1];
        bus.rsp_ready_0      = drv_rsp_ready[0];
        bus.rsp_ready_1      = drv_rsp_ready[1];
        bus.mem_ready        = drv_mem_ready;
        bus.mem_rsp_valid    = drv_rsp_valid;
        bus.mem_read_data    = drv_rdata;
    endfunction

    function automatic bit chance(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    function automatic void set_pend(input int r, input logic [RSW-1:0] rs, input logic [4:0] rd,
                                     input logic [31:0] addr, input logic [3:0] we,
                                     input logic [31:0] wd, input logic [3:0] re);
        pend_valid[r] = 1'b1;
        pend_rs[r]    = rs;
        pend_rd[r]    = rd;
        pend_addr[r]  = addr;
        pend_we[r]    = we;
        pend_wd[r]    = wd;
        pend_re[r]    = re;
    endfunction

    function automatic void new_stimulus();
        for (int r = 0; r < 2; r++) begin
            if (!pend_valid[r] && chance(p_req[r])) begin
                if ($urandom_range(1, 0) == 1)
                    set_pend(r, RSW'($urandom), 5'($urandom), $urandom, 4'($urandom), $urandom, 4'h0);
                else
                    set_pend(r, RSW'($urandom), 5'($urandom), $urandom, 4'h0, 32'h0, 4'($urandom));
            end
            drv_rsp_ready[r] = chance(p_rsp_ready[r]);
        end
        drv_mem_ready = chance(p_mem_ready);
        drv_rsp_valid = chance(p_rsp_valid);
        drv_rdata     = $urandom;
        rst           = chance(p_rst);
    endfunction

    function automatic void restim();
        new_stimulus();
        apply_drive();
    endfunction

    function automatic void capture();
        obs_req_ready[0]  = bus.req_ready_0;
        obs_req_ready[1]  = bus.req_ready_1;
        obs_rsp_valid[0]  = bus.rsp_valid_0;
        obs_rsp_valid[1]  = bus.rsp_valid_1;
        obs_rsp_rs[0]     = bus.rsp_rs_id_0;
        obs_rsp_rs[1]     = bus.rsp_rs_id_1;
        obs_rsp_rd[0]     = bus.rsp_reg_addr_0;
        obs_rsp_rd[1]     = bus.rsp_reg_addr_1;
        obs_rsp_data[0]   = bus.rsp_read_data_0;
        obs_rsp_data[1]   = bus.rsp_read_data_1;
        obs_mem_valid     = bus.mem_valid;
        obs_mem_addr      = bus.mem_address;
        obs_mem_we        = bus.mem_write_en;
        obs_mem_wd        = bus.mem_write_data;
        obs_mem_re        = bus.mem_read_en;
        obs_mem_rsp_ready = bus.mem_rsp_ready;
    endfunction

    // Expected grant: a stalled grant is kept; a full tracker blocks new grants;
    // otherwise the sole valid requester, or the contest winner.
    function automatic int expected_grant();
        bit v0, v1;
        v0 = pend_valid[0] && !rst;
        v1 = pend_valid[1] && !rst;
        if (locked >= 0) return locked;
        if (q.size() >= MAXO) return -1;
        if (v0 && v1) return (RR && last == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_check();
        int h;
        exp_g = expected_grant();
        if (!checking) return;
        check_eq("mem_valid", obs_mem_valid, exp_g >= 0);
        check_eq("req_ready_0", obs_req_ready[0], exp_g == 0 && drv_mem_ready);
        check_eq("req_ready_1", obs_req_ready[1], exp_g == 1 && drv_mem_ready);
        if (exp_g >= 0) begin
            check_eq("mem_address", obs_mem_addr, pend_addr[exp_g]);
            check_eq("mem_write_en", obs_mem_we, pend_we[exp_g]);
            check_eq("mem_write_data", obs_mem_wd, pend_wd[exp_g]);
            check_eq("mem_read_en", obs_mem_re, pend_re[exp_g]);
        end
        if (q.size() == 0) begin
            check_eq("rsp_valid_0_empty", obs_rsp_valid[0], 1'b0);
            check_eq("rsp_valid_1_empty", obs_rsp_valid[1], 1'b0);
            check_eq("mem_rsp_ready_empty", obs_mem_rsp_ready, 1'b0);
        end else begin
            h = q[0].idx;
            check_eq("rsp_valid_0", obs_rsp_valid[0], h == 0 && drv_rsp_valid);
            check_eq("rsp_valid_1", obs_rsp_valid[1], h == 1 && drv_rsp_valid);
            check_eq("mem_rsp_ready", obs_mem_rsp_ready, drv_rsp_ready[h]);
            check_eq("rsp_rs_id", obs_rsp_rs[h], q[0].rs);
            check_eq("rsp_reg_addr", obs_rsp_rd[h], q[0].rd);
            check_eq("rsp_read_data", obs_rsp_data[h], drv_rdata);
        end
    endtask

    function automatic void model_update();
        ent_t e;
        if (rst) begin
            if (exp_g >= 0 && drv_mem_ready) pend_valid[exp_g] = 1'b0;
            q.delete();
            locked = -1;
            last   = 1;
            return;
        end
        if (q.size() > 0 && drv_rsp_valid && drv_rsp_ready[q[0].idx]) begin
            e = q.pop_front();
            $display("RSP r%0d rs_id=%0d reg=%0d data=%08h", e.idx, e.rs, e.rd, drv_rdata);
        end
        if (exp_g >= 0) begin
            if (drv_mem_ready) begin
                e.idx = exp_g;
                e.rs  = pend_rs[exp_g];
                e.rd  = pend_rd[exp_g];
                q.push_back(e);
                $display("REQ r%0d rs_id=%0d reg=%0d addr=%08h we=%h re=%h",
                         exp_g, pend_rs[exp_g], pend_rd[exp_g], pend_addr[exp_g],
                         pend_we[exp_g], pend_re[exp_g]);
                pend_valid[exp_g] = 1'b0;
                locked = -1;
                last   = exp_g;
            end else begin
                locked = exp_g;
            end
        end
    endfunction

    task automatic cycle();
        @(negedge clk);
        capture();
        model_check();
        @(posedge clk);
        model_update();
        #1;
        restim();
    endtask

    function automatic void zero_knobs();
        p_req          = '{0, 0};
        p_rsp_ready    = '{0, 0};
        p_mem_ready    = 0;
        p_rsp_valid    = 0;
        p_rst          = 0;
        pend_valid     = '{1'b0, 1'b0};
        drv_rsp_ready  = '{1'b0, 1'b0};
        drv_mem_ready  = 1'b0;
        drv_rsp_valid  = 1'b0;
        drv_rdata      = 32'h0;
    endfunction

    task automatic do_reset();
        zero_knobs();
        rst = 1'b1;
        apply_drive();
        cycle();
    endtask

    initial begin
        for (int r = 0; r < 2; r++) set_pend(r, '0, '0, '0, '0, '0, '0);
        zero_knobs();
        rst = 1'b1;
        apply_drive();
        repeat (2) begin
            @(negedge clk);
            exp_g = -1;
            @(posedge clk);
            model_update();
            #1;
        end
        rst      = 1'b0;
        checking = 1'b1;

        // Reset state, with a stray memory response that must be ignored
        drv_rsp_valid = 1'b1;
        drv_rdata     = 32'hA5A5_A5A5;
        apply_drive();
        cycle();
        check_eq("rst_mem_valid", obs_mem_valid, 1'b0);
        check_eq("rst_req_ready_0", obs_req_ready[0], 1'b0);
        check_eq("rst_req_ready_1", obs_req_ready[1], 1'b0);
        check_eq("rst_rsp_valid_0", obs_rsp_valid[0], 1'b0);
        check_eq("rst_rsp_valid_1", obs_rsp_valid[1], 1'b0);
        check_eq("rst_mem_rsp_ready", obs_mem_rsp_ready, 1'b0);
        check_eq("rst_mem_address", obs_mem_addr, 32'h0);
        check_eq("rst_rsp_data_0", obs_rsp_data[0], 32'h0);
        check_eq("rst_rsp_rs_id_1", obs_rsp_rs[1], '0);

        // Both valid every cycle with mem_ready high: alternate or fixed winner
        do_reset();
        p_req = '{100, 100}; p_mem_ready = 100; p_rsp_valid = 100; p_rsp_ready = '{100, 100};
        restim();
        for (int i = 0; i < 8; i++) begin
            cycle();
            check_eq($sformatf("alt_grant%0d", i), {obs_req_ready[0], obs_req_ready[1]},
                     (RR && (i % 2 == 1)) ? 2'b01 : 2'b10);
        end

        // Stalled requester-1 load keeps the grant while requester 0 arrives
        do_reset();
        set_pend(1, 5'd2, 5'd4, 32'h0000_1000, 4'h0, 32'h0, 4'hF);
        apply_drive();
        cycle();
        check_eq("stall_addr_c1", obs_mem_addr, 32'h0000_1000);
        check_eq("stall_ready1_c1", obs_req_ready[1], 1'b0);
        set_pend(0, 5'd9, 5'd5, 32'h0000_2000, 4'h0, 32'h0, 4'hF);
        apply_drive();
        for (int i = 2; i <= 3; i++) begin
            cycle();
            check_eq($sformatf("stall_addr_c%0d", i), obs_mem_addr, 32'h0000_1000);
            check_eq($sformatf("stall_ready0_c%0d", i), obs_req_ready[0], 1'b0);
        end
        p_mem_ready = 100;
        restim();
        cycle();
        check_eq("stall_xfer_c4", obs_req_ready[1], 1'b1);
        check_eq("stall_addr_c4", obs_mem_addr, 32'h0000_1000);

        // Fill the tracker: the fifth request waits for a response to pop
        do_reset();
        p_req = '{100, 100}; p_mem_ready = 100;
        restim();
        for (int i = 0; i < MAXO + 2; i++) begin
            cycle();
            check_eq($sformatf("fill_valid%0d", i), obs_mem_valid, i < MAXO);
            if (i >= MAXO)
                check_eq($sformatf("fill_ready%0d", i), {obs_req_ready[0], obs_req_ready[1]}, 2'b00);
        end
        p_rsp_valid = 100; p_rsp_ready = '{100, 100};
        restim();
        cycle();
        check_eq("full_pop_ready", obs_mem_rsp_ready, 1'b1);
        check_eq("full_no_bypass", obs_mem_valid, 1'b0);
        p_rsp_valid = 0;
        restim();
        cycle();
        check_eq("full_resume", obs_mem_valid, 1'b1);

        // In-order response routing with tags
        do_reset();
        set_pend(0, 5'd3, 5'd1, 32'h0000_0100, 4'h0, 32'h0, 4'hF);
        set_pend(1, 5'd7, 5'd2, 32'h0000_0200, 4'h0, 32'h0, 4'hF);
        p_mem_ready = 100;
        restim();
        cycle();
        check_eq("order_req0", obs_req_ready[0], 1'b1);
        cycle();
        check_eq("order_req1", obs_req_ready[1], 1'b1);
        p_mem_ready = 0; p_rsp_valid = 100; p_rsp_ready = '{100, 100};
        restim();
        drv_rdata = 32'hDEAD_BEEF;
        apply_drive();
        cycle();
        check_eq("order_rsp0_valid", obs_rsp_valid[0], 1'b1);
        check_eq("order_rsp0_other", obs_rsp_valid[1], 1'b0);
        check_eq("order_rsp0_rs_id", obs_rsp_rs[0], 5'd3);
        check_eq("order_rsp0_data", obs_rsp_data[0], 32'hDEAD_BEEF);
        drv_rdata = 32'h1234_5678;
        apply_drive();
        cycle();
        check_eq("order_rsp1_valid", obs_rsp_valid[1], 1'b1);
        check_eq("order_rsp1_other", obs_rsp_valid[0], 1'b0);
        check_eq("order_rsp1_rs_id", obs_rsp_rs[1], 5'd7);
        check_eq("order_rsp1_data", obs_rsp_data[1], 32'h1234_5678);

        // Backpressured head, then push and pop together at occupancy 2
        do_reset();
        p_req[0] = 100; p_mem_ready = 100;
        restim();
        repeat (2) cycle();
        p_mem_ready = 0; p_rsp_valid = 100; p_rsp_ready = '{0, 100};
        restim();
        cycle();
        check_eq("bp_mem_rsp_ready", obs_mem_rsp_ready, 1'b0);
        check_eq("bp_rsp_valid_0", obs_rsp_valid[0], 1'b1);
        p_mem_ready = 100; p_rsp_ready = '{100, 100};
        restim();
        cycle();
        check_eq("pp_push", obs_req_ready[0], 1'b1);
        check_eq("pp_pop", obs_mem_rsp_ready, 1'b1);
        p_rsp_valid = 0;
        restim();
        for (int i = 0; i < MAXO - 1; i++) begin
            cycle();
            check_eq($sformatf("pp_after%0d", i), obs_mem_valid, i < MAXO - 2);
        end

        // Reset with three outstanding discards them
        do_reset();
        p_req[0] = 100; p_mem_ready = 100;
        restim();
        repeat (3) cycle();
        p_req[0] = 0; p_mem_ready = 0;
        restim();
        rst = 1'b1;
        apply_drive();
        cycle();
        p_rsp_valid = 100; p_rsp_ready = '{100, 100};
        restim();
        cycle();
        check_eq("mid_rst_mem_rsp_ready", obs_mem_rsp_ready, 1'b0);
        check_eq("mid_rst_rsp_valid_0", obs_rsp_valid[0], 1'b0);
        check_eq("mid_rst_rsp_valid_1", obs_rsp_valid[1], 1'b0);

        // Randomized traffic with occasional resets
        do_reset();
        for (int blk = 0; blk < 15; blk++) begin
            p_req       = '{int'($urandom_range(100, 10)), int'($urandom_range(100, 10))};
            p_mem_ready = int'($urandom_range(100, 20));
            p_rsp_valid = int'($urandom_range(100, 20));
            p_rsp_ready = '{int'($urandom_range(100, 30)), int'($urandom_range(100, 30))};
            p_rst       = (blk % 5 == 4) ? 2 : 0;
            for (int i = 0; i < 100; i++) cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter RS_ID_WIDTH, default 5, width of reservation-station tag.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, depth of response-tracking FIFO, power of two, 2..16.
REQ-003 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset), in that order; one clock, reset synchronous, active-high.
REQ-004 SHALL have, per requester r in {0,1}: req_valid_r (in, 1, request valid); req_ready_r (out, 1, request accepted); req_rs_id_r (in, RS_ID_WIDTH, tag); req_reg_addr_r (in, 5, target register); req_address_r (in, 32, byte address); req_write_en_r (in, 4, byte write enables); req_write_data_r (in, 32, store data); req_read_en_r (in, 4, byte read enables).
REQ-005 SHALL have, per requester r: rsp_valid_r (out, 1, response valid); rsp_ready_r (in, 1, response accepted); rsp_rs_id_r (out, RS_ID_WIDTH); rsp_reg_addr_r (out, 5); rsp_read_data_r (out, 32).
REQ-006 SHALL have memory-side ports: mem_valid (out, 1); mem_ready (in, 1); mem_address (out, 32); mem_write_en (out, 4); mem_write_data (out, 32); mem_read_en (out, 4); mem_rsp_valid (in, 1); mem_rsp_ready (out, 1); mem_read_data (in, 32).
REQ-007 SHALL use big-endian bit numbering [0:N-1] on all vector ports.

Function
REQ-008 SHALL share one memory port between requesters 0 and 1; each accepted request produces exactly one memory response (loads and stores), returned in issue order.
REQ-009 SHALL transfer a request only on a cycle where valid and ready are both high; mem_valid/req_ready are combinational from the held grant, no added request latency.
REQ-010 SHALL implement grant FSM: IDLE (no grant) -> GRANT_r when req_valid_r selected and tracking FIFO not full; GRANT_r -> IDLE on mem_ready (transfer); grant SHALL NOT change while in GRANT_r.
REQ-011 SHALL, in GRANT_r, drive mem_* from requester r, mem_valid=1, req_ready_r=mem_ready, other requester's req_ready=0.
REQ-012 SHALL, in IDLE, select combinationally and pass the selected request through in the same cycle (IDLE->transfer in one cycle if mem_ready=1, FSM stays IDLE).
REQ-013 SHALL not grant (mem_valid=0, all req_ready=0) while the FIFO holds MAX_OUTSTANDING entries; no same-cycle pop-then-push bypass.
REQ-014 SHALL push {requester index, rs_id, reg_addr} into the tracking FIFO on each memory request transfer.
REQ-015 SHALL route mem_rsp_valid/mem_read_data to rsp_*_r of the FIFO head's requester with head rs_id/reg_addr; mem_rsp_ready = rsp_ready of that requester; pop on mem_rsp_valid & mem_rsp_ready.
REQ-016 SHALL hold mem_rsp_ready=0 and all rsp_valid=0 when FIFO empty.
REQ-017 SHALL allow push and pop in the same cycle, occupancy unchanged; pointers wrap modulo MAX_OUTSTANDING.
REQ-018 SHALL hold rsp_valid of non-head requester at 0.

Reset
REQ-019 SHALL on rst: FSM to IDLE, FIFO empty (pointers and count 0), priority pointer to requester 0; outputs next cycle: mem_valid=0, all req_ready=0 (until re-evaluated), all rsp_valid=0, mem_rsp_ready=0, data outputs 0.
REQ-020 SHALL discard outstanding tracking entries when rst asserts mid-operation; responses arriving afterwards are not accepted.

Configuration
REQ-021 SHALL, with MEM_ARB_ROUND_ROBIN_EN defined, select in IDLE the requester not granted last when both valid (priority pointer toggles after each transfer).
REQ-022 SHALL, without MEM_ARB_ROUND_ROBIN_EN, use fixed priority: requester 0 always wins when both valid; priority pointer absent.

Verification
REQ-023 SHALL cover: both valid every cycle, mem_ready=1, round-robin build -> grants alternate 0,1,0,1; fixed build -> requester 0 always.
REQ-024 SHALL cover: requester 1 load to 0x0000_1000 with mem_ready=0 for 3 cycles, requester 0 raising valid meanwhile -> grant stays 1, mem_address stable 0x0000_1000, transfer on cycle 4.
REQ-025 SHALL cover: MAX_OUTSTANDING=4, four requests, no responses -> fifth held, all req_ready=0 until one response pops.
REQ-026 SHALL cover: requests r0(rs_id 3), r1(rs_id 7), responses 0xDEADBEEF then 0x12345678 -> rsp_0 gets rs_id 3/0xDEADBEEF, then rsp_1 rs_id 7/0x12345678.
REQ-027 SHALL cover: rsp_ready_0=0 with head for requester 0 -> mem_rsp_ready=0, response held; simultaneous push/pop at count 2 -> count stays 2.
REQ-028 SHALL cover: rst asserted with 3 outstanding -> count 0, mem_rsp_ready=0, rsp_valid=0 next cycle.
